// File: rtl/rsa_io_pkg.sv
// Shared types and constants for the interpreter byte-to-UART path.
package rsa_io_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [7:0] IDLE_CODE_DEFAULT = 8'd127;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer; a push into a full FIFO is still taken when a pop shares the cycle.
module byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset so it can map onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rsa_byte_uart_tx.sv
// Captures interpreter result bytes (dropping the idle code), buffers them and sends UART 8N1.
// IDLE: line high, pop when data | START: start bit | DATA: 8 bits LSB first | STOP: stop bit
module rsa_byte_uart_tx
  import rsa_io_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         BAUD       = 115_200,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] IDLE_CODE  = IDLE_CODE_DEFAULT,
  localparam int        CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_strobe,
  input  logic [7:0]       byte_in,
  output logic             tx,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;

  logic [2:0]    sync_q;
  logic [7:0]    dly1_q, dly2_q;
  logic          push, pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, ovf_q;
  logic          baud_last;

  // Data rides two stages so it lines up with the synchronised strobe edge.
  assign push      = sync_q[1] & ~sync_q[2] & (dly2_q != IDLE_CODE);
  assign baud_last = (baud_q == BW'(CPB - 1));

  byte_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (dly2_q),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so back-to-back bytes leave no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      dly1_q  <= '0;
      dly2_q  <= '0;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], byte_strobe};
      dly1_q  <= byte_in;
      dly2_q  <= dly1_q;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != IDLE) | ~fifo_empty;
      ovf_q   <= ovf_q | (push & fifo_full & ~pop);
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_rsa_byte_uart_tx.sv
// Randomised and directed bench for rsa_byte_uart_tx against a timestamp/queue reference model.
module tb_rsa_byte_uart_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;
  localparam int FRAME  = 10 * CPB;
  localparam int DEPTH  = 16;
  localparam logic [7:0] IDLE_B = 8'd127;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_strobe = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       tx, busy, overflow;
  logic [4:0] fifo_count;

  rsa_byte_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_strobe (byte_strobe),
    .byte_in     (byte_in),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: byte queue plus pop timestamps; a frame occupies FRAME clocks after its pop.
  logic [7:0] m_q[$];
  logic [7:0] pop_log[$];
  bit         m_ov = 0;
  bit         pipe0_v = 0, pipe1_v = 0, st_prev = 0;
  logic [7:0] pipe0_b = 0, pipe1_b = 0, last_byte = 0;
  int         mcyc = 0, last_pop = -1000, next_pop_ok = 0;
  bit         exp_tx = 1, exp_busy = 0;

  task automatic model_step();
    int k, s;
    bit nonidle_prev;
    if (reset) begin
      m_q.delete();
      m_ov = 0; pipe0_v = 0; pipe1_v = 0; st_prev = 0;
      last_pop = -1000; next_pop_ok = 0;
      exp_tx = 1; exp_busy = 0;
      return;
    end
    mcyc++;
    nonidle_prev = (mcyc - 1 <= last_pop + FRAME - 1);
    exp_busy = nonidle_prev || (m_q.size() != 0);
    if (m_q.size() > 0 && mcyc >= next_pop_ok) begin
      last_byte = m_q.pop_front();
      pop_log.push_back(last_byte);
      last_pop = mcyc;
      next_pop_ok = mcyc + FRAME;
    end
    if (pipe1_v && pipe1_b != IDLE_B) begin
      if (m_q.size() < DEPTH) m_q.push_back(pipe1_b);
      else m_ov = 1;
    end
    pipe1_v = pipe0_v; pipe1_b = pipe0_b;
    pipe0_v = byte_strobe && !st_prev; pipe0_b = byte_in;
    st_prev = byte_strobe;
    s = last_pop + 1;
    if (mcyc >= s && mcyc <= s + FRAME - 1) begin
      k = (mcyc - s) / CPB;
      if (k == 0)      exp_tx = 0;
      else if (k == 9) exp_tx = 1;
      else             exp_tx = last_byte[k-1];
    end else begin
      exp_tx = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Per-cycle line/status comparison plus a simple mid-bit UART receiver.
  bit         chk_en = 0;
  int         maxcnt = 0;
  logic [7:0] rx_q[$];
  bit         rx_act = 0;
  int         rx_t = 0;
  logic [7:0] rx_sh = 0;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (chk_en) begin
        chk("tx", tx, exp_tx);
        chk("busy", busy, exp_busy);
        chk("fifo_count", fifo_count, m_q.size());
        chk("overflow", overflow, m_ov);
      end
      if (int'(fifo_count) > maxcnt) maxcnt = fifo_count;
      if (!rx_act) begin
        if (tx == 1'b0) begin rx_act = 1; rx_t = 0; end
      end else begin
        rx_t++;
        if (rx_t >= 15 && rx_t <= 85 && (rx_t - 15) % 10 == 0) rx_sh[(rx_t - 15) / 10] = tx;
        if (rx_t == 95) begin rx_q.push_back(rx_sh); rx_act = 0; end
      end
    end else begin
      rx_act = 0;
    end
  end

  task automatic send(input logic [7:0] b, input int hi, input int gap);
    @(negedge clk);
    byte_in = b;
    byte_strobe = 1'b1;
    repeat (hi) @(negedge clk);
    byte_strobe = 1'b0;
    byte_in = 8'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || m_q.size() != 0 || rx_act) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk({tag, "_byte"}, rx_q[i], exp[i]);
    rx_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
  endtask

  initial begin
    logic [7:0] exp[$];
    int n, p;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    chk_en = 1;
    repeat (3) @(negedge clk);

    // single byte, strobe held high
    send(8'h41, 5, 5);
    drain(400);
    exp = '{8'h41};
    check_rx("single", exp);

    // idle code filtered
    maxcnt = 0;
    send(IDLE_B, 3, 6);
    send(8'h30, 3, 6);
    drain(400);
    chk("idle_maxcnt", maxcnt, 1);
    exp = '{8'h30};
    check_rx("idle", exp);

    // back-to-back
    for (int i = 1; i <= 4; i++) send(8'(i), 2, 2);
    drain(800);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_rx("b2b", exp);

    // overflow
    for (int i = 0; i < 20; i++) send(8'(i), 2, 2);
    repeat (4) @(negedge clk);
    chk("sat_count", fifo_count, 5'd16);
    chk("ovf_set", overflow, 1'b1);
    drain(2500);
    chk("ovf_sticky", overflow, 1'b1);
    exp.delete();
    for (int i = 0; i <= 16; i++) exp.push_back(8'(i));
    check_rx("ovf", exp);

    // reset mid-frame
    do_reset();
    send(8'hA5, 2, 2);
    send(8'h77, 2, 2);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("start_seen", tx, 1'b0);
    repeat (45) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_count", fifo_count, 5'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    repeat (150) @(negedge clk);
    chk("no_residual", rx_q.size(), 0);
    send(8'h5A, 2, 2);
    drain(400);
    exp = '{8'h5A};
    check_rx("after_rst", exp);

    // full FIFO with a push landing on the pop edge
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h80 + 8'(i), 2, 2);
    n = 0;
    while (mcyc != next_pop_ok - 3 && n < 200) begin @(negedge clk); n++; end
    p = next_pop_ok;
    chk("prefill_count", fifo_count, 5'd16);
    byte_in = 8'hC3;
    byte_strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    byte_strobe = 1'b0;
    @(negedge clk);
    if (mcyc == p) begin
      chk("fullpop_count", fifo_count, 5'd16);
      chk("fullpop_ovf", overflow, 1'b0);
    end else begin
      chk("fullpop_align", mcyc, p);
    end
    drain(2500);
    exp.delete();
    for (int i = 0; i < 17; i++) exp.push_back(8'h80 + 8'(i));
    exp.push_back(8'hC3);
    check_rx("fullpop", exp);
    chk("fullpop_ovf_end", overflow, 1'b0);

    // randomised traffic
    do_reset();
    pop_log.delete();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 7) == 0) ? IDLE_B : 8'($urandom_range(0, 255));
      send(b, $urandom_range(1, 6), $urandom_range(1, 150));
    end
    drain(6000);
    exp = pop_log;
    check_rx("random", exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rsa_byte_uart_tx.md
Name: rsa_byte_uart_tx

Overview:
- Downstream of the CPU's interpreter communication stage.
- Consumes its 8-bit result byte and its byte strobe, discards the idle code 127, and buffers real bytes in a small FIFO.
- Serialises buffered bytes as UART 8N1 to the host-side interpreter.
- Decouples CPU pipeline timing from the slow serial link.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115_200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division).
- FIFO_DEPTH, 16, byte buffer entries; power of two, at least 2.
- IDLE_CODE, 8'd127, upstream "no data" marker; never transmitted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- byte_strobe  in  1  upstream strobe; high while the upstream byte is valid.
- byte_in  in  8  upstream data byte.
- tx  out  1  UART line, idle high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- overflow  out  1  sticky; set when a byte is dropped on FIFO full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0; FIFO emptied; FSM in IDLE; baud counter and bit index cleared.
- Input alignment:
  - byte_strobe passes through a 2-flop synchroniser, then a rising-edge detector (third flop).
  - byte_in is delayed through a matching 2-stage register, so the captured byte is the one present when the strobe rose.
- Capture: on a detected rising edge, the aligned byte is pushed, except when it equals IDLE_CODE (silently discarded, no flag).
- Level-high strobe yields exactly one push; a new push needs a low-then-high transition.
- Push latency: byte enters the FIFO on the 3rd clk edge after byte_strobe rises.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set; overflow stays set until reset.
  - Push and pop in the same cycle leave the count unchanged.
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit. Shift right after each bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - No extra idle cycle between frames: if the FIFO is non-empty in IDLE, the pop happens that cycle.
- tx timing:
  - tx is registered (glitch-free).
  - tx falls one clk edge after the pop, so two edges after the push into an empty FIFO.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads on every state or bit change.
- busy = (state!=IDLE) | (fifo_count!=0), registered alongside the state.
- Reset mid-frame: tx returns to 1 immediately (asynchronous), the partial frame is abandoned, and buffered bytes are lost.

Decomposition:
- Shared package rsa_io_pkg holds:
  - typedef enum uart_state_t {IDLE, START, DATA, STOP};
  - constant IDLE_CODE_DEFAULT = 8'd127.
- Sub-module byte_fifo (parameterised DATA_W=8, DEPTH):
  - ports push, din, pop, dout, full, empty, count;
  - contains the pointer and wrap logic.
- Top level holds the synchroniser, edge detect, IDLE_CODE filter, overflow flag, and UART FSM.

Test Plan:
All scenarios use CLK_HZ=1_000_000, BAUD=100_000 (10 clks/bit).
- Single byte: strobe high with byte_in=8'h41 held 5 cycles -> exactly one frame on tx. Line sequence: start low 10 clks; bits 1,0,0,0,0,0,1,0 at 10 clks each; stop high 10 clks. busy falls after the stop bit.
- Idle filtering: strobe pulses with byte_in=127, then with 8'h30 -> only the 0x30 frame appears; fifo_count never exceeds 1.
- Back-to-back: 4 strobes carrying 8'h01,8'h02,8'h03,8'h04 spaced 4 clks apart -> 4 contiguous frames in order, 100 clks each, no gap between stop and next start.
- Overflow: 20 strobes (bytes 0..19, skipping 127) spaced 4 clks apart, FIFO_DEPTH=16.
  - fifo_count saturates at 16 and overflow goes high and stays high.
  - Transmitted bytes are 0,1,…,16 (byte 0 popped early frees one slot); later bytes are dropped.
- Reset mid-frame: assert reset during DATA bit 3 of 8'hA5 -> tx=1 in the same cycle; busy=0 and fifo_count=0. After release, no residual frame appears; a new strobe with 8'h5A transmits correctly.
- Full with simultaneous pop: FIFO at 16 entries, push arrives the same cycle the FSM pops -> push accepted, count stays 16, overflow stays 0.
